// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch stage.
package fetch_pkg;

  localparam int unsigned DEF_A     = 10;
  localparam int unsigned DEF_W     = 9;
  localparam int unsigned DEF_OFS_W = 8;

  localparam logic [DEF_W-1:0] DEF_HALT_WORD = 9'h1FF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } fetch_state_t;

  // Default-width next-PC rule: branch target when taken, otherwise sequential.
  function automatic logic [DEF_A-1:0] next_pc(
    input logic [DEF_A-1:0]     pc,
    input logic                 branch_en,
    input logic                 rel,
    input logic [DEF_A-1:0]     target,
    input logic [DEF_OFS_W-1:0] offset
  );
    logic [DEF_A-1:0] ofs_ext;
    ofs_ext = DEF_A'($signed(offset));
    if (!branch_en) return pc + DEF_A'(1);
    return rel ? (pc + ofs_ext) : target;
  endfunction

endpackage

// File: rtl/fetch_unit_pc_next_calc.sv
// Combinational next-PC: sequential increment or absolute/relative branch target.
module pc_next_calc
  import fetch_pkg::*;
#(
  parameter int unsigned A     = DEF_A,
  parameter int unsigned OFS_W = DEF_OFS_W
) (
  input  logic [A-1:0]     pc,
  input  logic             branch_en,
  input  logic             branch_rel,
  input  logic [A-1:0]     target,
  input  logic [OFS_W-1:0] offset,
  output logic [A-1:0]     pc_next
);

  logic [A-1:0] ofs_ext;

  always_comb begin
    ofs_ext = A'($signed(offset));
    pc_next = pc + A'(1);
    if (branch_en) begin
      pc_next = branch_rel ? (pc + ofs_ext) : target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// PC/fetch stage feeding a combinational instruction ROM; registers the word into IR.
// Optional FETCH_COUNT_EN adds a saturating FetchCount of live fetches.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned   A         = DEF_A,
  parameter int unsigned   W         = DEF_W,
  parameter int unsigned   OFS_W     = DEF_OFS_W,
  parameter logic [W-1:0]  HALT_WORD = W'(DEF_HALT_WORD)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Stall,
  input  logic             BranchEn,
  input  logic             BranchRel,
  input  logic [A-1:0]     Target,
  input  logic [OFS_W-1:0] Offset,
  input  logic [W-1:0]     InstIn,
  output logic [A-1:0]     InstAddress,
  output logic [W-1:0]     InstReg,
  output logic             InstValid,
  output logic [A-1:0]     PcOut,
  output logic             Done
`ifdef FETCH_COUNT_EN
  ,
  output logic [15:0]      FetchCount
`endif
);

  fetch_state_t   state_q, state_d;
  logic [A-1:0]   pc_q, pc_d;
  logic [W-1:0]   ir_q, ir_d;
  logic [A-1:0]   pc_out_q, pc_out_d;
  logic           valid_q, valid_d;
  logic           done_q, done_d;
  logic           armed_q, armed_d;
  logic           start_ok;
  logic [A-1:0]   pc_nxt;
`ifdef FETCH_COUNT_EN
  logic [15:0]    cnt_q, cnt_d;
`endif

  pc_next_calc #(
    .A     (A),
    .OFS_W (OFS_W)
  ) u_pc_next_calc (
    .pc         (pc_q),
    .branch_en  (BranchEn),
    .branch_rel (BranchRel),
    .target     (Target),
    .offset     (Offset),
    .pc_next    (pc_nxt)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    done_d   = done_q;
    armed_d  = 1'b1;
`ifdef FETCH_COUNT_EN
    cnt_d    = cnt_q;
`endif
    // armed_q stays low for the first edge after reset so a Start coincident with release is dropped
    start_ok = Start && armed_q;

    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = RUN;
          pc_d    = '0;
`ifdef FETCH_COUNT_EN
          cnt_d   = '0;
`endif
        end
      end
      RUN: begin
        if (BranchEn) begin
          pc_d    = pc_nxt;
          valid_d = 1'b0;
        end else if (!Stall) begin
          ir_d     = InstIn;
          pc_out_d = pc_q;
          if (InstIn == HALT_WORD) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = HALTED;
          end else begin
            valid_d = 1'b1;
            pc_d    = pc_nxt;
`ifdef FETCH_COUNT_EN
            if (cnt_q != '1) cnt_d = cnt_q + 16'd1;
`endif
          end
        end
      end
      HALTED: begin
        if (start_ok) begin
          state_d = RUN;
          pc_d    = '0;
          done_d  = 1'b0;
          valid_d = 1'b0;
`ifdef FETCH_COUNT_EN
          cnt_d   = '0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      armed_q  <= 1'b0;
`ifdef FETCH_COUNT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      armed_q  <= armed_d;
`ifdef FETCH_COUNT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign InstAddress = pc_q;
  assign InstReg     = ir_q;
  assign InstValid   = valid_q;
  assign PcOut       = pc_out_q;
  assign Done        = done_q;
`ifdef FETCH_COUNT_EN
  assign FetchCount  = cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized run against a behavioural model.
module tb_fetch_unit;

  localparam int unsigned A     = 10;
  localparam int unsigned W     = 9;
  localparam int unsigned OFS_W = 8;
  localparam int DEPTH  = 1 << A;
  localparam int HALT   = 'h1FF;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic             Clk = 1'b0;
  logic             Reset = 1'b0;
  logic             Start = 1'b0;
  logic             Stall = 1'b0;
  logic             BranchEn = 1'b0;
  logic             BranchRel = 1'b0;
  logic [A-1:0]     Target = '0;
  logic [OFS_W-1:0] Offset = '0;
  logic [W-1:0]     InstIn;
  logic [A-1:0]     InstAddress;
  logic [W-1:0]     InstReg;
  logic             InstValid;
  logic [A-1:0]     PcOut;
  logic             Done;
`ifdef FETCH_COUNT_EN
  logic [15:0]      FetchCount;
`endif

  logic [W-1:0] rom [0:DEPTH-1];

  int tests = 0;
  int fails = 0;

  int m_mode, m_pc, m_ir, m_pcout, m_count;
  bit m_valid, m_done, m_armed;

  fetch_unit #(
    .A     (A),
    .W     (W),
    .OFS_W (OFS_W)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .Stall       (Stall),
    .BranchEn    (BranchEn),
    .BranchRel   (BranchRel),
    .Target      (Target),
    .Offset      (Offset),
    .InstIn      (InstIn),
    .InstAddress (InstAddress),
    .InstReg     (InstReg),
    .InstValid   (InstValid),
    .PcOut       (PcOut),
    .Done        (Done)
`ifdef FETCH_COUNT_EN
    ,
    .FetchCount  (FetchCount)
`endif
  );

  always #5 Clk = ~Clk;

  assign InstIn = rom[InstAddress];

  task automatic model_reset();
    m_mode = M_IDLE; m_pc = 0; m_ir = 0; m_pcout = 0;
    m_valid = 0; m_done = 0; m_count = 0; m_armed = 0;
  endtask

  // Spec-level behaviour of one rising edge given the inputs currently applied.
  task automatic model_edge();
    int word;
    int ofs;
    word = int'(rom[m_pc]);
    ofs  = int'($signed(Offset));
    if (m_mode == M_IDLE) begin
      if (Start && m_armed) begin m_mode = M_RUN; m_pc = 0; m_count = 0; end
    end else if (m_mode == M_HALT) begin
      if (Start && m_armed) begin
        m_mode = M_RUN; m_pc = 0; m_done = 0; m_valid = 0; m_count = 0;
      end
    end else begin
      if (BranchEn) begin
        m_valid = 0;
        m_pc = BranchRel ? ((m_pc + ofs + DEPTH) % DEPTH) : int'(Target);
      end else if (!Stall) begin
        m_ir = word; m_pcout = m_pc;
        if (word == HALT) begin
          m_valid = 0; m_done = 1; m_mode = M_HALT;
        end else begin
          m_valid = 1; m_pc = (m_pc + 1) % DEPTH;
          if (m_count < 65535) m_count++;
        end
      end
    end
    m_armed = 1;
  endtask

  task automatic step(input bit st, input bit stl, input bit br, input bit rel,
                      input int tgt, input int ofs);
    Start = st; Stall = stl; BranchEn = br; BranchRel = rel;
    Target = A'(tgt); Offset = OFS_W'(ofs);
    if (Reset) model_edge();
    @(posedge Clk); #1;
    Start = 0; Stall = 0; BranchEn = 0; BranchRel = 0;
  endtask

  task automatic fill_rom(input int halt_pct);
    for (int i = 0; i < DEPTH; i++) begin
      if (int'($urandom_range(0, 99)) < halt_pct) rom[i] = W'(HALT);
      else rom[i] = W'($urandom_range(0, HALT - 1));
    end
  endtask

  task automatic reset_and_arm();
    Reset = 0; model_reset();
    @(posedge Clk); #1;
    Reset = 1;
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    #3;
    tests++; if (InstAddress !== '0) begin fails++; $display("FAIL rst_addr got %h want 0", InstAddress); end
    tests++; if (InstReg !== '0) begin fails++; $display("FAIL rst_ir got %h want 0", InstReg); end
    tests++; if (InstValid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b want 0", InstValid); end
    tests++; if (PcOut !== '0) begin fails++; $display("FAIL rst_pcout got %h want 0", PcOut); end
    tests++; if (Done !== 1'b0) begin fails++; $display("FAIL rst_done got %b want 0", Done); end
    fill_rom(0);
    reset_and_arm();
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0);
    tests++; if (InstAddress !== A'(5)) begin fails++; $display("FAIL mid_run_pc got %h want 005", InstAddress); end
    Reset = 0; model_reset();
    #2;
    tests++; if (InstAddress !== '0) begin fails++; $display("FAIL async_addr got %h want 0", InstAddress); end
    tests++; if (InstReg !== '0) begin fails++; $display("FAIL async_ir got %h want 0", InstReg); end
    tests++; if (InstValid !== 1'b0) begin fails++; $display("FAIL async_valid got %b want 0", InstValid); end
    tests++; if (PcOut !== '0) begin fails++; $display("FAIL async_pcout got %h want 0", PcOut); end
    @(posedge Clk); #1;
    Reset = 1;
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    tests++; if (InstValid !== 1'b0) begin fails++; $display("FAIL start_at_release_valid got %b want 0", InstValid); end
    tests++; if (InstAddress !== '0) begin fails++; $display("FAIL start_at_release_pc got %h want 0", InstAddress); end
  endtask

  task automatic test_sequential();
    fill_rom(0);
    for (int i = 0; i < 4; i++) rom[i] = W'(i + 1);
    reset_and_arm();
    step(1, 0, 0, 0, 0, 0);
    tests++; if (InstValid !== 1'b0) begin fails++; $display("FAIL seq_start_valid got %b want 0", InstValid); end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0);
      tests++; if (InstReg !== W'(i + 1)) begin fails++; $display("FAIL seq_ir[%0d] got %h want %h", i, InstReg, i + 1); end
      tests++; if (PcOut !== A'(i)) begin fails++; $display("FAIL seq_pcout[%0d] got %h want %h", i, PcOut, i); end
      tests++; if (InstValid !== 1'b1) begin fails++; $display("FAIL seq_valid[%0d] got %b want 1", i, InstValid); end
    end
  endtask

  task automatic test_abs_branch();
    step(0, 0, 1, 0, 'h3F0, 0);
    tests++; if (InstValid !== 1'b0) begin fails++; $display("FAIL abs_bubble got %b want 0", InstValid); end
    tests++; if (InstAddress !== A'('h3F0)) begin fails++; $display("FAIL abs_addr got %h want 3f0", InstAddress); end
    tests++; if (InstReg !== W'(4)) begin fails++; $display("FAIL abs_ir_hold got %h want 004", InstReg); end
    step(0, 0, 0, 0, 0, 0);
    tests++; if (InstReg !== rom['h3F0]) begin fails++; $display("FAIL abs_target_ir got %h want %h", InstReg, rom['h3F0]); end
    tests++; if (PcOut !== A'('h3F0)) begin fails++; $display("FAIL abs_target_pc got %h want 3f0", PcOut); end
    tests++; if (InstValid !== 1'b1) begin fails++; $display("FAIL abs_target_valid got %b want 1", InstValid); end
  endtask

  task automatic test_rel_branch_wrap();
    step(0, 0, 1, 0, 2, 0);
    step(0, 0, 1, 1, 0, 'hFE);
    tests++; if (InstAddress !== '0) begin fails++; $display("FAIL rel_neg got %h want 000", InstAddress); end
    tests++; if (InstValid !== 1'b0) begin fails++; $display("FAIL rel_bubble got %b want 0", InstValid); end
    step(0, 0, 1, 0, 'h3FF, 0);
    step(0, 0, 0, 0, 0, 0);
    tests++; if (PcOut !== A'('h3FF)) begin fails++; $display("FAIL wrap_pcout got %h want 3ff", PcOut); end
    tests++; if (InstAddress !== '0) begin fails++; $display("FAIL wrap_pc got %h want 000", InstAddress); end
  endtask

  task automatic test_stall();
    logic [W-1:0] held;
    step(0, 0, 1, 0, 6, 0);
    step(0, 0, 0, 0, 0, 0);
    held = rom[6];
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 0, 0);
      tests++; if (InstAddress !== A'(7)) begin fails++; $display("FAIL stall_pc[%0d] got %h want 007", i, InstAddress); end
      tests++; if (InstReg !== held) begin fails++; $display("FAIL stall_ir[%0d] got %h want %h", i, InstReg, held); end
      tests++; if (InstValid !== 1'b1) begin fails++; $display("FAIL stall_valid[%0d] got %b want 1", i, InstValid); end
    end
    step(0, 1, 1, 0, 'h20, 0);
    tests++; if (InstAddress !== A'('h20)) begin fails++; $display("FAIL stall_branch_pc got %h want 020", InstAddress); end
    tests++; if (InstValid !== 1'b0) begin fails++; $display("FAIL stall_branch_valid got %b want 0", InstValid); end
  endtask

  task automatic test_halt();
    fill_rom(0);
    rom[6] = W'(HALT);
    reset_and_arm();
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0);
    tests++; if (Done !== 1'b0) begin fails++; $display("FAIL pre_halt_done got %b want 0", Done); end
    step(0, 0, 0, 0, 0, 0);
    tests++; if (Done !== 1'b1) begin fails++; $display("FAIL halt_done got %b want 1", Done); end
    tests++; if (InstValid !== 1'b0) begin fails++; $display("FAIL halt_valid got %b want 0", InstValid); end
    tests++; if (InstReg !== W'(HALT)) begin fails++; $display("FAIL halt_ir got %h want 1ff", InstReg); end
    tests++; if (PcOut !== A'(6)) begin fails++; $display("FAIL halt_pcout got %h want 006", PcOut); end
`ifdef FETCH_COUNT_EN
    tests++; if (FetchCount !== 16'd6) begin fails++; $display("FAIL halt_count got %0d want 6", FetchCount); end
`endif
    step(0, 1, 1, 0, 'h100, 0);
    tests++; if (InstAddress !== A'(6)) begin fails++; $display("FAIL halted_frozen_pc got %h want 006", InstAddress); end
    tests++; if (Done !== 1'b1) begin fails++; $display("FAIL halted_frozen_done got %b want 1", Done); end
    step(1, 0, 0, 0, 0, 0);
    tests++; if (Done !== 1'b0) begin fails++; $display("FAIL restart_done got %b want 0", Done); end
    tests++; if (InstAddress !== '0) begin fails++; $display("FAIL restart_pc got %h want 000", InstAddress); end
`ifdef FETCH_COUNT_EN
    tests++; if (FetchCount !== 16'd0) begin fails++; $display("FAIL restart_count got %0d want 0", FetchCount); end
`endif
    step(0, 0, 0, 0, 0, 0);
    tests++; if (InstReg !== rom[0] || InstValid !== 1'b1) begin
      fails++; $display("FAIL restart_fetch got ir=%h v=%b want ir=%h v=1", InstReg, InstValid, rom[0]);
    end
  endtask

  task automatic test_random();
    int r;
    fill_rom(4);
    reset_and_arm();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r = int'($urandom_range(0, 99));
      if (r == 0) begin
        Reset = 0; model_reset();
        #1;
      end else begin
        step(($urandom_range(0, 99) < 6), ($urandom_range(0, 99) < 25),
             ($urandom_range(0, 99) < 15), ($urandom_range(0, 1) == 1),
             int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 255)));
      end
      tests++; if (InstAddress !== A'(m_pc)) begin fails++; $display("FAIL rnd_pc@%0d got %h want %h", cyc, InstAddress, m_pc); end
      tests++; if (InstReg !== W'(m_ir)) begin fails++; $display("FAIL rnd_ir@%0d got %h want %h", cyc, InstReg, m_ir); end
      tests++; if (InstValid !== m_valid) begin fails++; $display("FAIL rnd_valid@%0d got %b want %b", cyc, InstValid, m_valid); end
      tests++; if (PcOut !== A'(m_pcout)) begin fails++; $display("FAIL rnd_pcout@%0d got %h want %h", cyc, PcOut, m_pcout); end
      tests++; if (Done !== m_done) begin fails++; $display("FAIL rnd_done@%0d got %b want %b", cyc, Done, m_done); end
`ifdef FETCH_COUNT_EN
      tests++; if (FetchCount !== 16'(m_count)) begin fails++; $display("FAIL rnd_count@%0d got %0d want %0d", cyc, FetchCount, m_count); end
`endif
      if (r == 0) begin
        @(posedge Clk); #1;
        Reset = 1;
      end
    end
  endtask

  initial begin
    model_reset();
    fill_rom(0);
    test_reset();
    test_sequential();
    test_abs_branch();
    test_rel_branch_wrap();
    test_stall();
    test_halt();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
